// File: rtl/mux2_arb_pkg.sv
// Shared types for the two-requester arbitrated mux: FSM state encoding and datapath select values.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    function automatic logic is_grant(input state_t s);
        return (s == GNT1) || (s == GNT2);
    endfunction

endpackage

// File: rtl/mux2_arb_hold_cnt.sv
// Saturating hold counter: counts cycles a grant has been held, flags MAX_HOLD-1.
// Latency: count and flag registered; clear has priority over enable.
module mux2_arb_hold_cnt #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] LP_TC = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == LP_TC);
    assign o_tc = w_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester arbiter with bounded hold time driving a registered 1-bit shared mux.
// Latency: request at edge N -> grant after edge N; data one cycle; no backpressure beyond the grants.
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic clk,
    input  logic rst,
    input  logic mux_req1,
    input  logic mux_req2,
    input  logic mux_in1,
    input  logic mux_in2,
    output logic mux_gnt1,
    output logic mux_gnt2,
    output logic mux_sel,
    output logic mux_out,
    output logic mux_busy
);

    state_t r_state;
    state_t w_nxt;
    logic   r_last2;
    logic   r_gnt1;
    logic   r_gnt2;
    logic   r_sel;
    logic   r_out;
    logic   w_hold_tc;
    logic   w_enter1;
    logic   w_enter2;
    logic   w_clr;
    logic   w_en;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (mux_req1 && mux_req2) begin
                    w_nxt = r_last2 ? GNT1 : GNT2;
                end else if (mux_req1) begin
                    w_nxt = GNT1;
                end else if (mux_req2) begin
                    w_nxt = GNT2;
                end else begin
                    w_nxt = IDLE;
                end
            end
            // Losing the own request takes precedence over hold expiry.
            GNT1: begin
                if (!mux_req1) begin
                    w_nxt = mux_req2 ? GNT2 : IDLE;
                end else if (w_hold_tc && mux_req2) begin
                    w_nxt = GNT2;
                end else begin
                    w_nxt = GNT1;
                end
            end
            GNT2: begin
                if (!mux_req2) begin
                    w_nxt = mux_req1 ? GNT1 : IDLE;
                end else if (w_hold_tc && mux_req1) begin
                    w_nxt = GNT1;
                end else begin
                    w_nxt = GNT2;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    assign w_enter1 = (w_nxt == GNT1) && (r_state != GNT1);
    assign w_enter2 = (w_nxt == GNT2) && (r_state != GNT2);
    assign w_clr    = w_enter1 || w_enter2;
    assign w_en     = is_grant(r_state) && (w_nxt == r_state);

    mux2_arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (w_en),
        .o_tc  (w_hold_tc)
    );

    // Outputs decode from the next state so grant and data line up on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last2 <= 1'b1;
            r_gnt1  <= 1'b0;
            r_gnt2  <= 1'b0;
            r_sel   <= SEL_IN1;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_gnt1  <= (w_nxt == GNT1);
            r_gnt2  <= (w_nxt == GNT2);
            if (w_clr) begin
                r_last2 <= w_enter2;
            end
            case (w_nxt)
                GNT1: begin
                    r_sel <= SEL_IN1;
                    r_out <= mux_in1;
                end
                GNT2: begin
                    r_sel <= SEL_IN2;
                    r_out <= mux_in2;
                end
                default: begin
                    r_out <= 1'b0;
                end
            endcase
        end
    end

    assign mux_gnt1 = r_gnt1;
    assign mux_gnt2 = r_gnt2;
    assign mux_sel  = r_sel;
    assign mux_out  = r_out;
    assign mux_busy = r_gnt1 | r_gnt2;

    always_comb begin
        assert (!(r_gnt1 && r_gnt2));
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter with MAX_HOLD=4: directed steps queue expected outputs, a monitor compares.
module tb_mux2_arbiter;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic mux_req1 = 1'b0;
    logic mux_req2 = 1'b0;
    logic mux_in1  = 1'b0;
    logic mux_in2  = 1'b0;
    logic mux_gnt1;
    logic mux_gnt2;
    logic mux_sel;
    logic mux_out;
    logic mux_busy;

    typedef struct packed {
        logic g1;
        logic g2;
        logic sel;
        logic out;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mux2_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .mux_req1 (mux_req1),
        .mux_req2 (mux_req2),
        .mux_in1  (mux_in1),
        .mux_in2  (mux_in2),
        .mux_gnt1 (mux_gnt1),
        .mux_gnt2 (mux_gnt2),
        .mux_sel  (mux_sel),
        .mux_out  (mux_out),
        .mux_busy (mux_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Vector order: {gnt1, gnt2, sel, out, busy}
    task automatic check_outputs_zero(input string name);
        check(name, 32'({mux_gnt1, mux_gnt2, mux_sel, mux_out, mux_busy}), 32'd0);
    endtask

    task automatic step(input logic r1, input logic r2, input logic i1, input logic i2,
                        input logic g1, input logic g2, input logic sel, input logic out);
        exp_t e;
        @(negedge clk);
        rst      = 1'b0;
        mux_req1 = r1;
        mux_req2 = r2;
        mux_in1  = i1;
        mux_in2  = i2;
        e.g1  = g1;
        e.g2  = g2;
        e.sel = sel;
        e.out = out;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("grant_onehot", 32'(mux_gnt1 & mux_gnt2), 32'd0);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("outputs", 32'({mux_gnt1, mux_gnt2, mux_sel, mux_out, mux_busy}),
                      32'({e.g1, e.g2, e.sel, e.out, e.g1 | e.g2}));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #2 rst = 1'b1;
        #1 check_outputs_zero("reset_por");

        // Requester 1 alone, data toggles through with one-cycle latency.
        step(1, 0, 0, 1,  1, 0, 0, 0);
        step(1, 0, 1, 1,  1, 0, 0, 1);
        step(1, 0, 0, 1,  1, 0, 0, 0);
        step(0, 0, 1, 1,  0, 0, 0, 0);

        // Synchronous-looking reset, then contention: 4 cycles each, requester 1 first.
        @(negedge clk);
        rst      = 1'b1;
        mux_req1 = 1'b0;
        mux_req2 = 1'b0;
        #1 check_outputs_zero("reset_mid");
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0,  1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0,  0, 1, 1, 0);
        step(1, 1, 1, 0,  1, 0, 0, 1);
        step(0, 0, 1, 1,  0, 0, 0, 0);

        // Requester 2 alone for 10 cycles: no forced drop, counter saturates.
        for (int i = 0; i < 10; i++) step(0, 1, 1, i[0],  0, 1, 1, i[0]);
        @(posedge clk);
        #2 check("hold_saturated", 32'(dut.u_hold.r_cnt), 32'd3);
        // All requests drop in GNT2: idle, output cleared, select held.
        step(0, 0, 1, 1,  0, 0, 1, 0);

        // Own request falls in GNT1 cycle 2 with requester 2 waiting.
        step(1, 0, 1, 0,  1, 0, 0, 1);
        step(1, 1, 0, 0,  1, 0, 0, 0);
        step(0, 1, 1, 1,  0, 1, 1, 1);
        step(0, 1, 0, 1,  0, 1, 1, 1);

        // Asynchronous reset mid-GNT2, away from any clock edge.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_outputs_zero("reset_async");
        step(1, 1, 0, 1,  1, 0, 0, 0);
        step(1, 1, 1, 1,  1, 0, 0, 1);

        repeat (3) @(posedge clk);
        #2 check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles before forced hand-over when the other requester waits; legal range 2..256.
REQ-002 Parameter CNT_W, default $clog2(MAX_HOLD), hold-counter width; not overridden by users.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mux_req1  input  1  requester 1 wants the shared output.
REQ-006 mux_req2  input  1  requester 2 wants the shared output.
REQ-007 mux_in1  input  1  requester 1 data.
REQ-008 mux_in2  input  1  requester 2 data.
REQ-009 mux_gnt1  output  1  requester 1 owns the output (registered).
REQ-010 mux_gnt2  output  1  requester 2 owns the output (registered).
REQ-011 mux_sel  output  1  datapath select; 0 = input1, 1 = input2 (registered).
REQ-012 mux_out  output  1  registered shared output.
REQ-013 mux_busy  output  1  high whenever either grant is high.

Function
REQ-014 FSM states IDLE, GNT1, GNT2; state held in flops, next-state logic combinational.
REQ-015 IDLE: req1 only -> GNT1; req2 only -> GNT2; both -> requester not served last (priority pointer); neither -> stay IDLE.
REQ-016 Grant latency: request sampled at edge N yields grant high after edge N; no combinational req-to-gnt path.
REQ-017 GNTn with own request high: hold counter increments per cycle, saturating at MAX_HOLD-1.
REQ-018 GNTn, counter == MAX_HOLD-1, other request high -> switch to the other GNT state next edge; grant lasts exactly MAX_HOLD cycles under contention.
REQ-019 GNTn, counter saturated, other request low -> stay in GNTn indefinitely.
REQ-020 GNTn, own request low -> other GNT state if other request high (no idle bubble), else IDLE.
REQ-021 Simultaneous own-request drop and hold expiry: treated as REQ-020.
REQ-022 Hold counter clears to 0 on every entry into a GNT state, including GNT1->GNT2 switch.
REQ-023 Priority pointer updates to the served requester on each GNT-state entry.
REQ-024 mux_gnt1/mux_gnt2 one-hot or both zero; never both high.
REQ-025 mux_sel = 1 in GNT2, 0 in GNT1, holds last value in IDLE.
REQ-026 mux_out registered each edge: mux_in1 in GNT1, mux_in2 in GNT2, 0 in IDLE; data latency one cycle from input to mux_out.
REQ-027 mux_busy = mux_gnt1 | mux_gnt2 (combinational from registered grants).

Reset
REQ-028 rst high forces immediately, without clock: state IDLE, mux_gnt1=0, mux_gnt2=0, mux_sel=0, mux_out=0, counter=0, pointer = "requester 2 served last" (requester 1 wins first tie).
REQ-029 rst asserted mid-grant aborts the grant in the same cycle; first grant after release follows REQ-015/016.

Structure
REQ-030 Package mux2_arb_pkg holds state enum typedef (IDLE, GNT1, GNT2) and select constants SEL_IN1=0, SEL_IN2=1.
REQ-031 One sub-module mux2_arb_hold_cnt: saturating up-counter with clear, enable, terminal-count flag, parameterised by MAX_HOLD.
REQ-032 No latches; every combinational output assigned on all paths.

Verification (MAX_HOLD=4)
REQ-033 Reset then req1=1 only at edge 1 -> gnt1=1 after edge 1, mux_sel=0; mux_in1 toggling 0,1,0 appears on mux_out one cycle later.
REQ-034 req1=req2=1 from reset -> gnt1 for 4 cycles, then gnt2 for 4 cycles, then gnt1; never both grants high.
REQ-035 req2 alone held 10 cycles -> gnt2 high all 10 cycles, counter saturates at 3, no drop.
REQ-036 In GNT1 cycle 2, req1 falls while req2=1 -> gnt2=1 next edge, mux_busy stays 1, mux_sel=1.
REQ-037 rst pulsed asynchronously mid-GNT2 -> gnt2, mux_out, mux_sel drop to 0 before next edge; after release with both requesting, gnt1 wins.
REQ-038 All requests drop in GNT2 -> IDLE next edge, mux_out=0, mux_sel stays 1, mux_busy=0.
